// File: rtl/mat_pkg.sv
// Shared constants, state encoding and error causes for the matrix loader.
package mat_pkg;

    localparam int MAX_DIM = 16;
    localparam int DATA_W  = 32;

    typedef enum logic [2:0] {
        HDR_A  = 3'd0,
        LOAD_A = 3'd1,
        HDR_B  = 3'd2,
        LOAD_B = 3'd3,
        READY  = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_A_RANGE = 2'd1;
    localparam logic [1:0] ERR_B_RANGE = 2'd2;
    localparam logic [1:0] ERR_INNER   = 2'd3;

    // A dimension is usable when it is in 1..max_dim.
    function automatic logic dim_ok(input logic [15:0] d, input int max_dim);
        return (d != 16'd0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/mat_idx_cnt.sv
// Row-major element index counter: col wraps at cols-1 into the next row,
// and the whole counter returns to (0,0) after the final element.
module mat_idx_cnt #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [15:0]      rows_i,
    input  logic [15:0]      cols_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             col_end;
    logic             row_end;

    assign col_end = (16'(col_q) == (cols_i - 16'd1));
    assign row_end = (16'(row_q) == (rows_i - 16'd1));
    assign last_o  = col_end && row_end;
    assign row_o   = row_q;
    assign col_o   = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (inc_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/mat_load_ctrl.sv
// Parses a word stream of two headed matrices (A then B) into element writes
// for the matrix buffers, checks dimensions, and hands both off via mats_valid.
// Stream handshake: a word transfers on a rising edge where s_valid && s_ready;
// s_data must be stable while s_valid is high and s_ready is low.
module mat_load_ctrl
    import mat_pkg::*;
#(
    parameter int MAX_DIM = mat_pkg::MAX_DIM,
    parameter int DATA_W  = mat_pkg::DATA_W
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [DATA_W-1:0]                  s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic                               clear,
    output logic                               wr_en,
    output logic                               wr_sel,
    output logic [$clog2(MAX_DIM*MAX_DIM)-1:0] wr_addr,
    output logic [DATA_W-1:0]                  wr_data,
    output logic [15:0]                        rows_a,
    output logic [15:0]                        cols_a,
    output logic [15:0]                        rows_b,
    output logic [15:0]                        cols_b,
    output logic                               mats_valid,
    input  logic                               mats_ack,
    output logic                               err,
    output logic [1:0]                         err_code,
    output logic [2:0]                         dbg_state
);

    localparam int ADDR_W = $clog2(MAX_DIM*MAX_DIM);
    localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

    state_e              state_q, state_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [15:0]         rows_a_q, rows_a_d, cols_a_q, cols_a_d;
    logic [15:0]         rows_b_q, rows_b_d, cols_b_q, cols_b_d;
    logic                mats_valid_q, mats_valid_d;
    logic                wr_en_q, wr_en_d;
    logic                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                accept;
    logic                in_load;
    logic                cnt_inc;
    logic [15:0]         cnt_rows, cnt_cols;
    logic [IDX_W-1:0]    cnt_row, cnt_col;
    logic                cnt_last;
    logic [15:0]         hdr_rows, hdr_cols;
    logic                hdr_ok;
    logic [ADDR_W-1:0]   elem_addr;

    assign s_ready  = (state_q != READY);
    assign accept   = s_valid && s_ready;
    assign in_load  = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign cnt_inc  = accept && in_load && !clear;
    assign cnt_rows = (state_q == LOAD_B) ? rows_b_q : rows_a_q;
    assign cnt_cols = (state_q == LOAD_B) ? cols_b_q : cols_a_q;
    assign hdr_cols = s_data[31:16];
    assign hdr_rows = s_data[15:0];
    assign hdr_ok   = dim_ok(hdr_rows, MAX_DIM) && dim_ok(hdr_cols, MAX_DIM);
    assign elem_addr = ADDR_W'(32'(cnt_row) * 32'(MAX_DIM) + 32'(cnt_col));

    mat_idx_cnt #(
        .IDX_W (IDX_W)
    ) u_idx_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (clear),
        .inc_i  (cnt_inc),
        .rows_i (cnt_rows),
        .cols_i (cnt_cols),
        .row_o  (cnt_row),
        .col_o  (cnt_col),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        rows_a_d     = rows_a_q;
        cols_a_d     = cols_a_q;
        rows_b_d     = rows_b_q;
        cols_b_d     = cols_b_q;
        mats_valid_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (clear) begin
            state_d    = HDR_A;
            err_code_d = ERR_NONE;
        end else begin
            unique case (state_q)
                HDR_A: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            rows_a_d = hdr_rows;
                            cols_a_d = hdr_cols;
                            state_d  = LOAD_A;
                        end else begin
                            err_code_d = ERR_A_RANGE;
                            state_d    = ERR;
                        end
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = (state_q == LOAD_B);
                        wr_addr_d = elem_addr;
                        wr_data_d = s_data;
                        if (cnt_last) begin
                            state_d = (state_q == LOAD_A) ? HDR_B : READY;
                        end
                    end
                end
                HDR_B: begin
                    if (accept) begin
                        if (!hdr_ok) begin
                            err_code_d = ERR_B_RANGE;
                            state_d    = ERR;
                        end else if (hdr_rows != cols_a_q) begin
                            err_code_d = ERR_INNER;
                            state_d    = ERR;
                        end else begin
                            rows_b_d = hdr_rows;
                            cols_b_d = hdr_cols;
                            state_d  = LOAD_B;
                        end
                    end
                end
                // mats_valid is registered off the READY state so it rises
                // one cycle after the final B write strobe.
                READY: begin
                    if (mats_ack) begin
                        state_d = HDR_A;
                    end else begin
                        mats_valid_d = 1'b1;
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = HDR_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= HDR_A;
            err_code_q   <= ERR_NONE;
            rows_a_q     <= '0;
            cols_a_q     <= '0;
            rows_b_q     <= '0;
            cols_b_q     <= '0;
            mats_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            rows_a_q     <= rows_a_d;
            cols_a_q     <= cols_a_d;
            rows_b_q     <= rows_b_d;
            cols_b_q     <= cols_b_d;
            mats_valid_q <= mats_valid_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rows_a     = rows_a_q;
    assign cols_a     = cols_a_q;
    assign rows_b     = rows_b_q;
    assign cols_b     = cols_b_q;
    assign mats_valid = mats_valid_q;
    assign err        = (state_q == ERR);
    assign err_code   = err_code_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mat_load_ctrl.sv
// Directed-plus-random bench for mat_load_ctrl: a row-major write model fills
// an expected queue that a write monitor drains.
module tb_mat_load_ctrl;
    import mat_pkg::*;

    localparam int MD = 16;
    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          clear = 1'b0;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [15:0]   rows_a, cols_a, rows_b, cols_b;
    logic          mats_valid;
    logic          mats_ack = 1'b0;
    logic          err;
    logic [1:0]    err_code;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [40:0] exp_q[$];

    mat_load_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rows_a     (rows_a),
        .cols_a     (cols_a),
        .rows_b     (rows_b),
        .cols_b     (cols_b),
        .mats_valid (mats_valid),
        .mats_ack   (mats_ack),
        .err        (err),
        .err_code   (err_code),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Every write strobe must match the oldest outstanding modelled element.
    always @(negedge clk) begin
        if (rstn && wr_en) begin
            logic [40:0] e;
            check("write_expected", 64'(wr_en), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_sel_addr_data", 64'({wr_sel, wr_addr, wr_data}), 64'(e));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one word after gap idle cycles; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w, input int gap);
        bit done = 1'b0;
        cycles(gap);
        s_valid = 1'b1;
        s_data  = w;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (s_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $error("FAIL accept_timeout: observed s_ready=0 for 64 cycles required accept");
        end
    endtask

    task automatic send_matrix(input bit sel, input int rows, input int cols, input int gapmax);
        logic [31:0] d;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                d = $urandom;
                exp_q.push_back({sel, AW'(r * MD + c), d});
                send_word(d, $urandom_range(gapmax, 0));
            end
        end
    endtask

    task automatic load_pair(input int ra, input int ca, input int cb, input int gapmax);
        send_word({16'(ca), 16'(ra)}, $urandom_range(gapmax, 0));
        send_matrix(1'b0, ra, ca, gapmax);
        send_word({16'(cb), 16'(ca)}, $urandom_range(gapmax, 0));
        send_matrix(1'b1, ca, cb, gapmax);
    endtask

    // Called right after the final B accept: checks handoff timing and ack.
    task automatic finish_pair(input int ra, input int ca, input int cb);
        check("last_wr_en", 64'(wr_en), 64'd1);
        check("mv_not_yet", 64'(mats_valid), 64'd0);
        cycles(1);
        check("mv_after_last_write", 64'(mats_valid), 64'd1);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        check("dims", 64'({rows_a, cols_a, rows_b, cols_b}),
              64'({16'(ra), 16'(ca), 16'(ca), 16'(cb)}));
        for (int i = 0; i < 2; i++) begin
            check("ready_sready_low", 64'(s_ready), 64'd0);
            cycles(1);
        end
        check("mv_holds", 64'(mats_valid), 64'd1);
        mats_ack = 1'b1;
        cycles(1);
        check("mv_drop_on_ack", 64'(mats_valid), 64'd0);
        check("state_after_ack", 64'(dbg_state), 64'(HDR_A));
        cycles(2);
        mats_ack = 1'b0;
        check("ack_ignored_state", 64'(dbg_state), 64'(HDR_A));
        check("ack_ignored_sready", 64'(s_ready), 64'd1);
        check("ack_ignored_mv", 64'(mats_valid), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        check("clear_state", 64'(dbg_state), 64'(HDR_A));
        check("clear_err", 64'({err, err_code, mats_valid}), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check(tag, 64'({wr_en, wr_sel, wr_addr, wr_data}), 64'd0);
        check({tag, "_dims"}, 64'({rows_a, cols_a, rows_b, cols_b}), 64'd0);
        check({tag, "_flags"}, 64'({mats_valid, err, err_code}), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'(HDR_A));
        check({tag, "_sready"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        int ra, ca, cb;
        #2;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycles(2);

        // Example load: A 2x3, B 3x2, back to back.
        load_pair(2, 3, 2, 0);
        finish_pair(2, 3, 2);

        // Same load with random idle gaps.
        load_pair(2, 3, 2, 5);
        finish_pair(2, 3, 2);

        // A header with rows=0.
        send_word(32'h0005_0000, 0);
        check("a_range_err", 64'({err, err_code}), 64'({1'b1, ERR_A_RANGE}));
        check("err_sready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 3; i++) send_word($urandom, 0);
        cycles(2);
        check("err_holds", 64'({err, err_code}), 64'({1'b1, ERR_A_RANGE}));
        do_clear();

        // Inner-dimension mismatch: A 2x3 then B rows=2.
        send_word(32'h0003_0002, 0);
        send_matrix(1'b0, 2, 3, 1);
        send_word(32'h0002_0002, 0);
        check("inner_err", 64'({err, err_code}), 64'({1'b1, ERR_INNER}));
        cycles(1);
        check("inner_writes_drained", 64'(exp_q.size()), 64'd0);
        do_clear();

        // B column count out of range.
        send_word(32'h0002_0002, 0);
        send_matrix(1'b0, 2, 2, 0);
        send_word(32'h0011_0002, 0);
        check("b_range_err", 64'({err, err_code}), 64'({1'b1, ERR_B_RANGE}));
        cycles(1);
        do_clear();

        // Clear coincident with the 4th A element suppresses its write.
        send_word(32'h0003_0002, 0);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = $urandom;
            exp_q.push_back({1'b0, AW'(i), d});
            send_word(d, 0);
        end
        s_valid = 1'b1;
        s_data  = $urandom;
        clear   = 1'b1;
        cycles(1);
        s_valid = 1'b0;
        clear   = 1'b0;
        check("clear_on_elem_state", 64'(dbg_state), 64'(HDR_A));
        check("clear_on_elem_no_wr", 64'(wr_en), 64'd0);
        cycles(1);
        check("clear_on_elem_drained", 64'(exp_q.size()), 64'd0);
        load_pair(2, 3, 2, 1);
        finish_pair(2, 3, 2);

        // Smallest matrices.
        load_pair(1, 1, 1, 0);
        finish_pair(1, 1, 1);
        load_pair(1, 1, 4, 2);
        finish_pair(1, 1, 4);

        // Largest allowed dimensions.
        load_pair(16, 16, 16, 0);
        finish_pair(16, 16, 16);

        // Random dimensions.
        for (int k = 0; k < 3; k++) begin
            ra = $urandom_range(MD, 1);
            ca = $urandom_range(MD, 1);
            cb = $urandom_range(MD, 1);
            load_pair(ra, ca, cb, 2);
            finish_pair(ra, ca, cb);
        end

        // Reset applied mid-load.
        send_word(32'h0004_0004, 0);
        send_matrix(1'b0, 1, 4, 0);
        cycles(2);
        rstn = 1'b0;
        #1;
        check_reset_values("midload_reset");
        cycles(2);
        rstn = 1'b1;
        cycles(1);
        check("midload_drained", 64'(exp_q.size()), 64'd0);
        load_pair(3, 2, 5, 1);
        finish_pair(3, 2, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mat_load_ctrl.md
MAT_LOAD_CTRL -- requirements
Module: mat_load_ctrl

Interface
REQ-001 SHALL have parameter MAX_DIM, default 16, meaning maximum rows and maximum columns of one matrix.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word and element width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge clocked.
REQ-004 SHALL have port rstn, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL have port s_data, input, DATA_W bits, UART word stream data.
REQ-006 SHALL have port s_valid, input, 1 bit, s_data valid.
REQ-007 SHALL have port s_ready, output, 1 bit, word accepted when s_valid && s_ready.
REQ-008 SHALL have port clear, input, 1 bit, synchronous abort pulse.
REQ-009 SHALL have port wr_en, output, 1 bit, matrix buffer write strobe.
REQ-010 SHALL have port wr_sel, output, 1 bit, target buffer (0 = A, 1 = B).
REQ-011 SHALL have port wr_addr, output, clog2(MAX_DIM*MAX_DIM) bits, element address row*MAX_DIM+col.
REQ-012 SHALL have port wr_data, output, DATA_W bits, element value.
REQ-013 SHALL have ports rows_a, cols_a, rows_b, cols_b, output, 16 bits each, latched dimensions.
REQ-014 SHALL have port mats_valid, output, 1 bit, both matrices loaded and consistent.
REQ-015 SHALL have port mats_ack, input, 1 bit, consumer has finished with the loaded matrices.
REQ-016 SHALL have ports err, output, 1 bit, and err_code, output, 2 bits, error flag and cause.

Function
REQ-017 SHALL use states HDR_A, LOAD_A, HDR_B, LOAD_B, READY, ERR.
REQ-018 SHALL drive s_ready=1 in HDR_A, LOAD_A, HDR_B, LOAD_B and ERR, and s_ready=0 in READY.
REQ-019 SHALL decode a header word as cols=s_data[31:16], rows=s_data[15:0].
REQ-020 SHALL, on a header accepted in HDR_A with 1<=rows,cols<=MAX_DIM, latch rows_a/cols_a and go to LOAD_A; otherwise go to ERR with err_code=1.
REQ-021 SHALL, in HDR_B, check range identically (else ERR, err_code=2) and require rows_b==cols_a (else ERR, err_code=3); on success latch rows_b/cols_b and go to LOAD_B.
REQ-022 SHALL, in LOAD states, treat each accepted word as the next element in row-major order; col wraps to 0 at cols-1 and increments row.
REQ-023 SHALL register each write: wr_en pulses for exactly one cycle, the cycle after the accept, with the matching wr_sel/wr_addr/wr_data; with no accept, wr_en=0.
REQ-024 SHALL, on acceptance of element (rows-1, cols-1), move LOAD_A to HDR_B and LOAD_B to READY, and clear the row/col counters.
REQ-025 SHALL assert mats_valid in READY, starting the cycle after the final B wr_en and holding until mats_ack.
REQ-026 SHALL, on mats_ack in READY, deassert mats_valid next cycle and return to HDR_A; rows/cols outputs hold until overwritten; mats_ack outside READY is ignored.
REQ-027 SHALL, in ERR, hold err=1 and err_code, and accept and discard words, issuing no writes.
REQ-028 SHALL, on clear (any state, priority over all events), go to HDR_A next cycle, zero counters, err, err_code and mats_valid, and suppress a write whose accept coincides with clear.
REQ-029 SHALL handle s_valid gaps of any length without changing counters.
REQ-030 SHALL support 1x1 matrices, where a single element completes a load.

Reset
REQ-031 SHALL, while rstn=0, set state=HDR_A, counters=0, dims=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, mats_valid=0, err=0, err_code=0; s_ready follows state (1).
REQ-032 SHALL resume at HDR_A after reset deassertion, including reset applied mid-load.

Structure
REQ-033 SHALL take MAX_DIM, DATA_W, the state enum and the err_code constants (NONE=0, A_RANGE=1, B_RANGE=2, INNER=3) from the shared package mat_pkg.
REQ-034 SHALL instantiate one sub-module, mat_idx_cnt, a row/col counter with wrap detection and a last flag.

Verification
REQ-035 SHALL cover: headers 0x00030002 (A: 2 rows x 3 cols) and 0x00020003 (B: 3 rows x 2 cols) followed by 12 elements -> writes at A addrs 0,1,2,16,17,18 and B addrs 0,1,16,17,32,33; mats_valid=1 the cycle after the last write.
REQ-036 SHALL cover: header 0x00050000 (rows=0) -> err=1, err_code=1, no wr_en.
REQ-037 SHALL cover: A 2x3, then B header with rows=2 -> err_code=3; then clear -> err=0 and state HDR_A.
REQ-038 SHALL cover: random s_valid gaps of 0-5 cycles -> write sequence identical to REQ-035.
REQ-039 SHALL cover: clear coincident with the 4th A element -> no write for it; a fresh full load completes correctly.
REQ-040 SHALL cover: mats_ack held 3 cycles after mats_valid -> s_ready=0 throughout READY, then return to HDR_A.
